fetch_unit: RTL and testbench

Program-counter and fetch sequencer sitting directly downstream of the control decoder. It holds the PC that addresses the instruction ROM. Each running cycle it advances the PC sequentially or loads the decoder's branch target when `Jump_en` is asserted. It also sequences program start/halt with a simple handshake and keeps a saturating cycle count for benchmarking.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_sat_counter.sv | 23 ++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the fetch sequencer.
package definitions;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int kPC_W = 10;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear beats enable so a restart in the same cycle always lands on zero.
    always_ff @(posedge CLK) begin
        if (i_clr)
            r_q <= '0;
        else if (i_en && (r_q != {W{1'b1}}))
            r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// PC register, next-PC select and start/halt sequencing for the instruction ROM.
import definitions::*;

module fetch_unit #(
    parameter int PC_W = kPC_W,
    parameter int CT_W = 16
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] Start_addr,
    input  logic            Halt,
    input  logic            Jump_en,
    input  logic [15:0]     Target,
    output logic [PC_W-1:0] PC,
    output logic            Fetch_valid,
    output logic            Done,
    output logic [CT_W-1:0] Cycle_ct
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            w_run;
    logic            w_start_acc;
    logic            w_unused_tgt;

    assign w_run        = (r_state == RUN);
    assign w_start_acc  = Start && !w_run;
    // Upper branch-target bits never reach the PC.
    assign w_unused_tgt = ^Target[15:PC_W];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (Start) begin
                        r_state <= RUN;
                        r_pc    <= Start_addr;
                    end
                end
                RUN: begin
                    if (Halt)
                        r_state <= HALTED;
                    else if (Jump_en)
                        r_pc <= Target[PC_W-1:0];
                    else
                        r_pc <= r_pc + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_pc    <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CT_W)) u_cycle_ct (
        .CLK   (CLK),
        .i_clr (Reset || w_start_acc),
        .i_en  (w_run),
        .o_q   (Cycle_ct)
    );

    assign PC          = r_pc;
    assign Fetch_valid = w_run;
    assign Done        = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset, Start, Halt, Jump_en;
    logic [9:0]  Start_addr;
    logic [15:0] Target;
    logic [9:0]  PC, PC4;
    logic        Fetch_valid, Done, Fetch_valid4, Done4;
    logic [15:0] Cycle_ct;
    logic [3:0]  Cycle_ct4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 halted
    int m_state, m_pc, m_ct, m_ct4;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_W(10), .CT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Start_addr(Start_addr),
        .Halt(Halt), .Jump_en(Jump_en), .Target(Target),
        .PC(PC), .Fetch_valid(Fetch_valid), .Done(Done), .Cycle_ct(Cycle_ct)
    );

    fetch_unit #(.PC_W(10), .CT_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Start_addr(Start_addr),
        .Halt(Halt), .Jump_en(Jump_en), .Target(Target),
        .PC(PC4), .Fetch_valid(Fetch_valid4), .Done(Done4), .Cycle_ct(Cycle_ct4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc",       32'(PC),          32'(m_pc));
        chk("valid",    32'(Fetch_valid), 32'(m_state == 1));
        chk("done",     32'(Done),        32'(m_state == 2));
        chk("cycle_ct", 32'(Cycle_ct),    32'(m_ct));
        chk("pc4",      32'(PC4),         32'(m_pc));
        chk("ct4",      32'(Cycle_ct4),   32'(m_ct4));
    endtask

    task automatic model_step(input bit rst, input bit st, input int addr,
                              input bit h, input bit j, input int tgt);
        if (rst) begin
            m_state = 0; m_pc = 0; m_ct = 0; m_ct4 = 0;
        end else if (m_state == 1) begin
            m_ct  = (m_ct  < 65535) ? m_ct + 1  : 65535;
            m_ct4 = (m_ct4 < 15)    ? m_ct4 + 1 : 15;
            if (h)      m_state = 2;
            else if (j) m_pc = tgt % 1024;
            else        m_pc = (m_pc + 1) % 1024;
        end else if (st) begin
            m_state = 1; m_pc = addr; m_ct = 0; m_ct4 = 0;
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input logic [9:0] addr,
                       input bit h, input bit j, input logic [15:0] tgt);
        @(negedge CLK);
        Reset = rst; Start = st; Start_addr = addr; Halt = h; Jump_en = j; Target = tgt;
        @(posedge CLK);
        model_step(rst, st, int'(addr), h, j, int'(tgt));
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 10'h0, 0, 0, 16'h0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Start_addr = '0; Halt = 1'b0; Jump_en = 1'b0; Target = '0;
        m_state = 0; m_pc = 0; m_ct = 0; m_ct4 = 0;

        cyc(1, 0, 10'h0, 0, 0, 16'h0);
        cyc(1, 0, 10'h0, 0, 0, 16'h0);
        idle(2);                                 // IDLE holds, jump ignored below
        cyc(0, 0, 10'h0, 0, 1, 16'h0123);

        cyc(0, 1, 10'h003, 0, 0, 16'h0);         // start at 0x003
        idle(4);                                 // PC 0x007
        chk("pc_after_4", 32'(PC), 32'h7);

        cyc(0, 0, 10'h0, 0, 1, 16'h0010);
        cyc(0, 0, 10'h0, 0, 1, 16'h01FF);
        chk("jump_1ff", 32'(PC), 32'h1FF);
        cyc(0, 0, 10'h0, 0, 1, 16'hFC05);
        chk("jump_trunc", 32'(PC), 32'h005);
        cyc(0, 1, 10'h2AA, 0, 1, 16'h03FF);      // start ignored in RUN
        idle(1);
        chk("wrap", 32'(PC), 32'h000);
        chk("wrap_valid", 32'(Fetch_valid), 32'h1);

        cyc(0, 0, 10'h0, 0, 1, 16'h0020);
        cyc(0, 0, 10'h0, 1, 1, 16'h0099);        // halt beats jump
        chk("halt_pc", 32'(PC), 32'h020);
        idle(3);
        cyc(0, 0, 10'h0, 1, 1, 16'h0044);        // ignored in HALTED
        cyc(0, 1, 10'h100, 0, 0, 16'h0);
        chk("restart_pc", 32'(PC), 32'h100);
        chk("restart_ct", 32'(Cycle_ct), 32'h0);

        idle(20);                                // 4-bit counter saturates
        chk("ct4_sat", 32'(Cycle_ct4), 32'hF);
        cyc(0, 0, 10'h0, 0, 1, 16'h0055);
        cyc(1, 0, 10'h0, 0, 0, 16'h0);           // reset mid-run
        chk("rst_pc", 32'(PC), 32'h0);
        cyc(1, 1, 10'h155, 0, 0, 16'h0);         // reset beats start
        chk("rst_start_valid", 32'(Fetch_valid), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 20),
                10'($urandom), ($urandom_range(99) < 5),
                ($urandom_range(99) < 30), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
